// File: rtl/dphy_align_pkg.sv
// Shared types and constants for the D-PHY HS byte aligner.
package dphy_align_pkg;

    // Aligner state machine
    typedef enum logic [1:0] {
        StIdle,
        StHunt,
        StLocked,
        StErr
    } align_state_e;

    // HS sync byte as it appears after LSB-first deserialization
    localparam logic [7:0] SyncByteDefault = 8'hB8;

    // Width of the bit-offset field (offsets 0..8)
    localparam int unsigned OffsetW = 4;

endpackage

// File: rtl/sync_offset_encoder.sv
// Lowest-index priority encoder for the 9-position sync match vector.
module sync_offset_encoder
    import dphy_align_pkg::*;
(
    input  logic [8:0]         match,
    output logic [OffsetW-1:0] offset,
    output logic               found
);

    // Scan from the top down so the lowest set position is the last one written
    always_comb begin
        found  = |match;
        offset = '0;
        for (int k = 8; k >= 0; k--) begin
            if (match[k]) begin
                offset = OffsetW'(k);
            end
        end
    end

endmodule

// File: rtl/dphy_hs_byte_aligner.sv
// Finds the HS sync byte at any bit offset in the raw byte stream, locks that
// offset and emits aligned payload bytes until the lane leaves HS.
module dphy_hs_byte_aligner
    import dphy_align_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SyncByteDefault,
    parameter int unsigned SYNC_TIMEOUT = 32,
    parameter int unsigned TMO_W        = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hs_active,
    input  logic [7:0]         byte_in,
    input  logic               byte_in_valid,
    output logic [7:0]         data_out,
    output logic               data_valid,
    output logic               locked,
    output logic [OffsetW-1:0] offset,
    output logic               sync_found,
    output logic               sync_err,
    output logic               hs_end
);

    align_state_e       state_q;
    logic [7:0]         prev_byte_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [15:0]        win;
    logic [15:0]        win_shifted;
    logic [8:0]         match;
    logic [OffsetW-1:0] enc_offset;
    logic               enc_found;

    // Two-byte window: earlier byte in the low half, so bit 0 is oldest
    always_comb begin
        win         = {byte_in, prev_byte_q};
        win_shifted = win >> offset;
        for (int k = 0; k < 9; k++) begin
            match[k] = (win[k +: 8] == SYNC_BYTE);
        end
    end

    sync_offset_encoder u_encoder (
        .match  (match),
        .offset (enc_offset),
        .found  (enc_found)
    );

    // Aligner FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            prev_byte_q <= '0;
            tmo_cnt_q   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            locked      <= 1'b0;
            offset      <= '0;
            sync_found  <= 1'b0;
            sync_err    <= 1'b0;
            hs_end      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            sync_found <= 1'b0;
            sync_err   <= 1'b0;
            hs_end     <= 1'b0;
            if (!hs_active) begin
                // Leaving HS overrides everything, including a byte on this cycle
                state_q   <= StIdle;
                locked    <= 1'b0;
                offset    <= '0;
                tmo_cnt_q <= '0;
                hs_end    <= (state_q == StLocked);
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // Clearing the window makes the leading HS-zero bits implicit
                        state_q     <= StHunt;
                        prev_byte_q <= '0;
                        tmo_cnt_q   <= '0;
                    end
                    StHunt: begin
                        if (byte_in_valid) begin
                            prev_byte_q <= byte_in;
                            // Lock takes priority over a coincident timeout
                            if (enc_found) begin
                                offset     <= enc_offset;
                                locked     <= 1'b1;
                                sync_found <= 1'b1;
                                tmo_cnt_q  <= '0;
                                state_q    <= StLocked;
                            end else if (tmo_cnt_q == TMO_W'(SYNC_TIMEOUT - 1)) begin
                                sync_err <= 1'b1;
                                state_q  <= StErr;
                            end else begin
                                tmo_cnt_q <= tmo_cnt_q + 1'b1;
                            end
                        end
                    end
                    StLocked: begin
                        // No re-hunt mid-burst: the match vector is ignored here
                        if (byte_in_valid) begin
                            prev_byte_q <= byte_in;
                            data_out    <= win_shifted[7:0];
                            data_valid  <= 1'b1;
                        end
                    end
                    StErr: begin
                        if (byte_in_valid) begin
                            prev_byte_q <= byte_in;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dphy_hs_byte_aligner.sv
// Directed bench for the HS byte aligner with hand-computed expectations.
module tb_dphy_hs_byte_aligner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs_active = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_in_valid = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       locked;
    logic [3:0] offset;
    logic       sync_found;
    logic       sync_err;
    logic       hs_end;

    int n_vec = 0;
    int n_err = 0;

    dphy_hs_byte_aligner dut (
        .clk           (clk),
        .rst           (rst),
        .hs_active     (hs_active),
        .byte_in       (byte_in),
        .byte_in_valid (byte_in_valid),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .locked        (locked),
        .offset        (offset),
        .sync_found    (sync_found),
        .sync_err      (sync_err),
        .hs_end        (hs_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge
    task automatic step(input logic hs, input logic vld, input logic [7:0] b);
        hs_active     = hs;
        byte_in_valid = vld;
        byte_in       = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] all_outs();
        return {data_out, data_valid, locked, offset, sync_found, sync_err, hs_end};
    endfunction

    // Shifted-sync scenario, optionally with an idle cycle after every byte
    task automatic run_shifted(input logic gapped, input string nm);
        logic [7:0] bytes [5];
        logic [7:0] exp_out [5];
        bytes   = '{8'h00, 8'hC0, 8'h8D, 8'h10, 8'h01};
        exp_out = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, bytes[i]);
            check({nm, "_found"}, 16'(sync_found), 16'(i == 2));
            check({nm, "_dv"}, 16'(data_valid), 16'(i >= 3));
            if (i == 2) check({nm, "_offset"}, 16'(offset), 16'd3);
            if (i >= 3) check({nm, "_dout"}, 16'(data_out), 16'(exp_out[i]));
            if (gapped) begin
                step(1'b1, 1'b0, 8'hFF);
                check({nm, "_gap_dv"}, 16'(data_valid), 16'd0);
                if (i >= 3) check({nm, "_gap_hold"}, 16'(data_out), 16'(exp_out[i]));
            end
        end
        step(1'b0, 1'b0, 8'h00);
        check({nm, "_hs_end"}, 16'(hs_end), 16'd1);
        step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // Reset
        step(1'b1, 1'b1, 8'hB8);
        step(1'b1, 1'b1, 8'hB8);
        check("reset_outs", all_outs(), 16'h0000);
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        check("idle_outs", all_outs(), 16'h0000);

        // Byte-aligned sync, then HS exit with a dropped byte
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h00);
        check("al_nofound", 16'(sync_found), 16'd0);
        step(1'b1, 1'b1, 8'hB8);
        check("al_found", 16'(sync_found), 16'd1);
        check("al_locked", 16'(locked), 16'd1);
        check("al_offset", 16'(offset), 16'd8);
        check("al_no_sync_out", 16'(data_valid), 16'd0);
        step(1'b1, 1'b1, 8'h11);
        check("al_dout0", {7'(0), data_valid, data_out}, 16'h0111);
        check("al_pulse_gone", 16'(sync_found), 16'd0);
        step(1'b1, 1'b1, 8'h22);
        check("al_dout1", {7'(0), data_valid, data_out}, 16'h0122);
        step(1'b1, 1'b1, 8'h33);
        check("al_dout2", {7'(0), data_valid, data_out}, 16'h0133);
        step(1'b0, 1'b1, 8'h44);
        check("exit_hs_end", 16'(hs_end), 16'd1);
        check("exit_dropped", 16'(data_valid), 16'd0);
        check("exit_locked", 16'(locked), 16'd0);
        check("exit_offset", 16'(offset), 16'd0);
        step(1'b0, 1'b0, 8'h00);
        check("exit_hs_end_once", 16'(hs_end), 16'd0);

        // Shifted sync, contiguous and gapped
        run_shifted(1'b0, "sh");
        run_shifted(1'b1, "gap");

        // Timeout after 32 non-matching bytes
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b1, 8'h55);
            check("tmo_err", 16'(sync_err), 16'(i == 31));
            check("tmo_nolock", {locked, data_valid}, 16'd0);
        end
        step(1'b1, 1'b1, 8'hB8);
        check("err_no_relock", {locked, sync_found, sync_err}, 16'd0);
        step(1'b1, 1'b0, 8'h00);
        check("err_stays", {locked, sync_err, data_valid}, 16'd0);
        step(1'b0, 1'b0, 8'h00);
        check("err_no_hs_end", 16'(hs_end), 16'd0);

        // Lock on the same byte that would otherwise time out
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 31; i++) step(1'b1, 1'b1, 8'h55);
        step(1'b1, 1'b1, 8'hB8);
        check("race_found", {sync_found, sync_err}, 16'b10);
        check("race_offset", 16'(offset), 16'd8);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Reset mid-burst, then re-hunt starting from a cleared window
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'hB8);
        step(1'b1, 1'b1, 8'hC0);
        check("rb_dout", {7'(0), data_valid, data_out}, 16'h01C0);
        rst = 1'b1;
        step(1'b1, 1'b1, 8'h77);
        check("rb_outs", all_outs(), 16'h0000);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h00);
        check("rb_no_hs_end", 16'(hs_end), 16'd0);
        step(1'b1, 1'b1, 8'h8D);
        check("rb_clean_window", {locked, sync_found}, 16'd0);
        step(1'b1, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'hB8);
        check("rb_relock", {locked, offset}, 16'h0018);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
